// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions. Glyphs are active-low with bit order {g,f,e,d,c,b,a}.
package sseg_pkg;

  typedef logic [6:0] sseg_t;

  localparam sseg_t SSEG_BLANK = 7'h7F;

  localparam sseg_t SSEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/sseg2hex.sv
// Combinational reverse lookup: an active-low glyph is turned back into its hex nibble.
// Any pattern that is not one of the 16 glyphs, blank included, gives nibble 0 and err=1.
module sseg2hex
  import sseg_pkg::*;
(
  input  sseg_t      seg,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SSEG_CODE[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Reads a multiplexed active-low 7-segment bus back into a hex word. Inputs are synchronised, then
// captured once per stable period, and a frame is flagged when every digit has been seen.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an,
  input  sseg_t                 sseg,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic [DIGITS-1:0]     seen
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int PW = DIGITS + 7;
  localparam logic [PW-1:0] IDLE = {{DIGITS{1'b1}}, SSEG_BLANK};

  logic [PW-1:0]     sync1, sync2, prev;
  logic [CW-1:0]     cnt;
  logic [DIGITS-1:0] an_s, an_n, seen_next;
  sseg_t             sseg_s;
  logic              same, one_hot, capture;
  logic [3:0]        nib;
  logic              nib_err;

  assign an_s    = sync2[PW-1:7];
  assign sseg_s  = sync2[6:0];
  assign an_n    = ~an_s;
  assign same    = (sync2 == prev);
  assign one_hot = (an_n != '0) && ((an_n & (an_n - 1'b1)) == '0);
  // The 7->8 step happens only once per stable period, which is what makes capture single-shot.
  assign capture = same && (cnt == CW'(STABLE_CYCLES - 1)) && one_hot;
  assign seen_next = seen | an_n;

  sseg2hex u_sseg2hex (
    .seg    (sseg_s),
    .nibble (nib),
    .err    (nib_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
      prev  <= IDLE;
      cnt   <= '0;
    end else begin
      sync1 <= {an, sseg};
      sync2 <= sync1;
      prev  <= sync2;
      if (!same)
        cnt <= CW'(1);
      else if (cnt != CW'(STABLE_CYCLES))
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      digit_err   <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (capture) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (an_n[i]) begin
            value[4*i +: 4] <= nib;
            digit_err[i]    <= nib_err;
          end
        end
        if (&seen_next) begin
          seen        <= '0;
          frame_valid <= 1'b1;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Table-driven bench for sseg_scan_decoder: each held bus pair schedules its expected capture
// in a queue, and every cycle the outputs are compared against the last popped expectation.
module tb_sseg_scan_decoder;

  localparam int STABLE = 8;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         hold;
    bit         cap;
    logic [3:0] nib;
    bit         err;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] value;
    logic [3:0]  err;
    logic [3:0]  seen;
    bit          fv;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  sseg = 7'h7F;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic [3:0]  seen;

  always #5 clk = ~clk;

  sseg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .sseg        (sseg),
    .value       (value),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .seen        (seen)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  sb_t         sbq[$];
  logic [15:0] exp_value = '0;
  logic [3:0]  exp_err = '0;
  logic [3:0]  exp_seen = '0;
  bit          exp_fv = 1'b0;
  logic [15:0] m_value = '0;
  logic [3:0]  m_err = '0;
  logic [3:0]  m_seen = '0;
  vec_t        vecs [16];

  task automatic step();
    sb_t e;
    @(posedge clk);
    cyc++;
    #1;
    exp_fv = 1'b0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      exp_value = e.value;
      exp_err   = e.err;
      exp_seen  = e.seen;
      exp_fv    = e.fv;
    end
    checks++;
    if ({value, digit_err, seen, frame_valid} !== {exp_value, exp_err, exp_seen, exp_fv}) begin
      errors++;
      $display("FAIL outputs cyc=%0d: got value=%h err=%b seen=%b fv=%b, want value=%h err=%b seen=%b fv=%b",
               cyc, value, digit_err, seen, frame_valid, exp_value, exp_err, exp_seen, exp_fv);
    end
  endtask

  task automatic drive(input vec_t v);
    int  d;
    bit  fv;
    an   = v.an;
    sseg = v.seg;
    if (v.cap) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (!v.an[i]) d = i;
      m_value[4*d +: 4] = v.nib;
      m_err[d]          = v.err;
      m_seen            = m_seen | 4'(1 << d);
      fv                = (m_seen == 4'hF);
      if (fv) m_seen = '0;
      sbq.push_back('{cyc + STABLE + 2, m_value, m_err, m_seen, fv});
    end
    repeat (v.hold) step();
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 7'h7F, 100, 1'b0, 4'h0, 1'b0};
    vecs[1]  = '{4'b1110, 7'h30, 20,  1'b1, 4'h3, 1'b0};
    vecs[2]  = '{4'b1110, 7'h12, 20,  1'b1, 4'h5, 1'b0};
    vecs[3]  = '{4'b1101, 7'h10, 20,  1'b1, 4'h9, 1'b0};
    vecs[4]  = '{4'b1011, 7'h08, 20,  1'b1, 4'hA, 1'b0};
    vecs[5]  = '{4'b0111, 7'h0E, 20,  1'b1, 4'hF, 1'b0};
    vecs[6]  = '{4'b1101, 7'h7F, 20,  1'b1, 4'h0, 1'b1};
    vecs[7]  = '{4'b1101, 7'h55, 20,  1'b1, 4'h0, 1'b1};
    vecs[8]  = '{4'b1111, 7'h7F, 6,   1'b0, 4'h0, 1'b0};
    vecs[9]  = '{4'b1101, 7'h55, 20,  1'b1, 4'h0, 1'b1};
    vecs[10] = '{4'b1011, 7'h24, 7,   1'b0, 4'h0, 1'b0};
    vecs[11] = '{4'b1011, 7'h7F, 1,   1'b0, 4'h0, 1'b0};
    vecs[12] = '{4'b1011, 7'h24, 20,  1'b1, 4'h2, 1'b0};
    vecs[13] = '{4'b1100, 7'h08, 30,  1'b0, 4'h0, 1'b0};
    vecs[14] = '{4'b0111, 7'h40, 7,   1'b0, 4'h0, 1'b0};
    vecs[15] = '{4'b0111, 7'h40, 25,  1'b1, 4'h0, 1'b0};

    repeat (3) step();
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) drive(vecs[i]);

    // Counter now sits at 5 on a fresh pair; pull reset between edges.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({value, digit_err, seen, frame_valid} !== 25'b0) begin
      errors++;
      $display("FAIL async_reset: got value=%h err=%b seen=%b fv=%b, want all zero",
               value, digit_err, seen, frame_valid);
    end
    sbq.delete();
    exp_value = '0; exp_err = '0; exp_seen = '0;
    m_value = '0; m_err = '0; m_seen = '0;
    repeat (3) step();
    rst_n = 1'b1;
    drive(vecs[15]);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_captures: got %0d left in queue, want 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
